uart_sample_packer: RTL and testbench

//  Consumer stage directly downstream of the UART receiver.
//  - Takes the receiver's one-cycle byte strobes and packs byte pairs (low byte first) into 16-bit signed samples.
//  - Writes each sample into the FFT input sample RAM at sequential addresses.
//  - After N_SAMPLES writes, holds frame-ready to the FFT controller until it acknowledges.
//  - Resynchronises byte pairing after an inter-byte gap timeout.

---
 rtl/uart_sample_packer.sv | 94 +++++++++
 tb/tb_uart_sample_packer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_packer.sv
// Packs UART byte pairs (low byte first) into 16-bit samples and writes a frame of N_SAMPLES to the FFT sample RAM.
// Latency: high-byte strobe to RAM write strobe is 1 clock; frame-ready follows the last write by 1 clock.
// Backpressure: none toward the receiver; bytes arriving while a full frame is held are dropped and flagged as overrun.
module uart_sample_packer #(
    parameter int N_SAMPLES = 64,
    parameter int ADDR_W    = 6,
    parameter int GAP_TICKS = 5000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_flag,
    input  logic [7:0]        i_rx_byte,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_frame_ready,
    input  logic              i_frame_ack,
    output logic              o_overrun
);

    localparam int                GAP_W    = $clog2(GAP_TICKS);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        s_LOW  = 2'd0,
        s_HIGH = 2'd1,
        s_FULL = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        low_byte;
    logic [GAP_W-1:0]  gap_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= s_LOW;
            idx           <= '0;
            low_byte      <= '0;
            gap_cnt       <= '0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_frame_ready <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                s_LOW: begin
                    if (i_rx_flag) begin
                        low_byte <= i_rx_byte;
                        gap_cnt  <= '0;
                        state    <= s_HIGH;
                    end
                end
                s_HIGH: begin
                    // A flag on the timeout cycle still completes the pair.
                    if (i_rx_flag) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= idx;
                        o_wr_data <= {i_rx_byte, low_byte};
                        if (idx == IDX_LAST) begin
                            state <= s_FULL;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= s_LOW;
                        end
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= s_LOW;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                s_FULL: begin
                    // The index stays at the last address until the frame is released.
                    if (i_frame_ack) begin
                        o_frame_ready <= 1'b0;
                        o_overrun     <= 1'b0;
                        idx           <= '0;
                        state         <= s_LOW;
                    end else begin
                        o_frame_ready <= 1'b1;
                        if (i_rx_flag) begin
                            o_overrun <= 1'b1;
                        end
                    end
                end
                default: state <= s_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sample_packer.sv
// Bench for uart_sample_packer: directed scenarios plus randomized byte streams checked against a timestamp-based model.
module tb_uart_sample_packer;

    localparam int N   = 64;
    localparam int AW  = 6;
    localparam int GAP = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_flag = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          frame_ack = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_ready;
    logic          overrun;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_writes = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: pairing decided by the distance between byte arrival edges.
    bit m_full, m_over, m_have;
    int m_idx, m_low, m_low_t;

    logic [AW-1:0] last_addr = '0;
    logic [15:0]   last_data = '0;

    uart_sample_packer #(.N_SAMPLES(N), .ADDR_W(AW), .GAP_TICKS(GAP)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rx_flag(rx_flag),
        .i_rx_byte(rx_byte),
        .o_wr_en(wr_en),
        .o_wr_addr(wr_addr),
        .o_wr_data(wr_data),
        .o_frame_ready(frame_ready),
        .i_frame_ack(frame_ack),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the next predicted write, including its clock.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr <= '0;
            last_data <= '0;
        end else if (wr_en === 1'b1) begin
            n_writes++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got addr=%0d data=%h at cyc %0d, required no write", wr_addr, wr_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wr_addr !== e.addr[AW-1:0] || wr_data !== e.data[15:0] || cyc !== e.cyc) begin
                    fails++;
                    $display("FAIL write_match: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
            last_addr <= wr_addr;
            last_data <= wr_data;
        end else begin
            tests++;
            if (wr_addr !== last_addr || wr_data !== last_data) begin
                fails++;
                $display("FAIL hold_values: got addr=%0d data=%h, required addr=%0d data=%h", wr_addr, wr_data, last_addr, last_data);
            end
        end
    end

    task automatic model_reset();
        m_full = 0; m_over = 0; m_have = 0; m_idx = 0; m_low = 0; m_low_t = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input int b, input int t);
        wr_t w;
        if (m_full) begin
            m_over = 1;
        end else if (m_have && (t - m_low_t) <= GAP) begin
            w.addr = m_idx; w.data = (b << 8) | m_low; w.cyc = t;
            exp_q.push_back(w);
            m_have = 0;
            if (m_idx == N - 1) m_full = 1;
            else m_idx++;
        end else begin
            m_have = 1; m_low = b; m_low_t = t;
        end
    endtask

    task automatic do_reset();
        rx_flag = 0; frame_ack = 0;
        @(posedge clk); #1;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic send(input int b);
        @(posedge clk); #1;
        rx_flag = 1; rx_byte = b[7:0];
        model_byte(b, cyc + 1);
        @(posedge clk); #1;
        rx_flag = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_ack(input bit with_flag, input int b);
        @(posedge clk); #1;
        frame_ack = 1; rx_flag = with_flag; rx_byte = b[7:0];
        if (m_full) begin
            m_full = 0; m_over = 0; m_idx = 0; m_have = 0;
        end else if (with_flag) begin
            model_byte(b, cyc + 1);
        end
        @(posedge clk); #1;
        frame_ack = 0; rx_flag = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #23;
        tests++;
        if ({wr_en, wr_addr, wr_data, frame_ready, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required all zero", {wr_en, wr_addr, wr_data, frame_ready, overrun});
        end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_single_pair();
        int w0;
        w0 = n_writes;
        send(8'h34); send(8'h12); idle(4);
        tests++;
        if (n_writes - w0 !== 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL single_pair_count: got %0d writes (%0d pending), required 1", n_writes - w0, exp_q.size());
        end
        tests++;
        if (last_addr !== 0 || last_data !== 16'h1234) begin
            fails++;
            $display("FAIL single_pair_data: got addr=%0d data=%h, required addr=0 data=1234", last_addr, last_data);
        end
    endtask

    task automatic test_full_frame();
        int w0;
        do_reset();
        w0 = n_writes;
        for (int i = 0; i < 2 * N; i++) send(i);
        tests++;
        if (frame_ready !== 1'b0) begin
            fails++;
            $display("FAIL frame_ready_early: got %b during last strobe, required 0", frame_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL frame_ready_set: got %b one clock after last strobe, required 1", frame_ready);
        end
        tests++;
        if (n_writes - w0 !== N || last_addr !== N - 1 || last_data !== 16'h7F7E) begin
            fails++;
            $display("FAIL full_frame: got %0d writes last addr=%0d data=%h, required %0d writes addr=63 data=7f7e",
                     n_writes - w0, last_addr, last_data, N);
        end
    endtask

    task automatic test_overrun_ack();
        int w0;
        w0 = n_writes;
        send(8'hAA); idle(2);
        tests++;
        if (overrun !== 1'b1 || frame_ready !== 1'b1 || n_writes != w0) begin
            fails++;
            $display("FAIL overrun_set: got overrun=%b ready=%b writes=%0d, required 1 1 0", overrun, frame_ready, n_writes - w0);
        end
        send_ack(0, 0);
        tests++;
        if (overrun !== 1'b0 || frame_ready !== 1'b0) begin
            fails++;
            $display("FAIL ack_clear: got overrun=%b ready=%b, required 0 0", overrun, frame_ready);
        end
        send(8'h11); send(8'h22); idle(2);
        tests++;
        if (last_addr !== 0 || last_data !== 16'h2211 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL after_ack_write: got addr=%0d data=%h, required addr=0 data=2211", last_addr, last_data);
        end
    endtask

    task automatic test_gap_discard();
        int w0;
        w0 = n_writes;
        send(8'h55); idle(GAP); send(8'h01); send(8'h02); idle(2);
        tests++;
        if (n_writes - w0 !== 1 || last_addr !== 1 || last_data !== 16'h0201) begin
            fails++;
            $display("FAIL gap_discard: got %0d writes addr=%0d data=%h, required 1 write addr=1 data=0201",
                     n_writes - w0, last_addr, last_data);
        end
    endtask

    task automatic test_timeout_edge();
        send(8'hA1); idle(GAP - 2); send(8'hB2); idle(2);
        tests++;
        if (last_addr !== 2 || last_data !== 16'hB2A1) begin
            fails++;
            $display("FAIL timeout_flag_wins: got addr=%0d data=%h, required addr=2 data=b2a1", last_addr, last_data);
        end
        send(8'hC3); idle(GAP - 1); send(8'hD4); send(8'hE5); idle(2);
        tests++;
        if (last_addr !== 3 || last_data !== 16'hE5D4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_plus_one: got addr=%0d data=%h, required addr=3 data=e5d4", last_addr, last_data);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) send(8'h40 + i);
        idle(2);
        @(posedge clk); #1;
        rst_n = 0;
        model_reset();
        #1;
        tests++;
        if ({wr_en, wr_addr, wr_data, frame_ready, overrun} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %b, required all zero", {wr_en, wr_addr, wr_data, frame_ready, overrun});
        end
        idle(2); #1 rst_n = 1;
        send(8'h77); send(8'h88); idle(2);
        tests++;
        if (last_addr !== 0 || last_data !== 16'h8877) begin
            fails++;
            $display("FAIL mid_reset_restart: got addr=%0d data=%h, required addr=0 data=8877", last_addr, last_data);
        end
    endtask

    task automatic test_ack_with_flag();
        do_reset();
        for (int i = 0; i < 2 * N; i++) send($urandom_range(0, 255));
        send(8'h99); idle(1);
        tests++;
        if (overrun !== 1'b1 || frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_overrun: got overrun=%b ready=%b, required 1 1", overrun, frame_ready);
        end
        send_ack(1, 8'h5A);
        tests++;
        if (overrun !== 1'b0 || frame_ready !== 1'b0) begin
            fails++;
            $display("FAIL ack_with_flag: got overrun=%b ready=%b, required 0 0", overrun, frame_ready);
        end
        send(8'h01); send(8'hF0); idle(2);
        tests++;
        if (last_addr !== 0 || last_data !== 16'hF001 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL ack_with_flag_restart: got addr=%0d data=%h, required addr=0 data=f001", last_addr, last_data);
        end
    endtask

    task automatic test_random_stream();
        int n;
        do_reset();
        for (int it = 0; it < 450; it++) begin
            if (m_full) begin
                @(posedge clk); #1;
                tests++;
                if (frame_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL rand_ready: got %b, required 1", frame_ready);
                end
                if ($urandom_range(0, 1) == 1) begin
                    send($urandom_range(0, 255));
                    tests++;
                    if (overrun !== m_over) begin
                        fails++;
                        $display("FAIL rand_overrun: got %b, required %b", overrun, m_over);
                    end
                end
                idle($urandom_range(0, 5));
                send_ack($urandom_range(0, 1), $urandom_range(0, 255));
                tests++;
                if (frame_ready !== 1'b0 || overrun !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_ack: got ready=%b overrun=%b, required 0 0", frame_ready, overrun);
                end
            end else begin
                case ($urandom_range(0, 2))
                    0:       n = $urandom_range(0, 3);
                    1:       n = $urandom_range(GAP - 4, GAP + 1);
                    default: n = $urandom_range(0, 12);
                endcase
                idle(n);
                send($urandom_range(0, 255));
            end
        end
        idle(4);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_missing_writes: got %0d predicted writes never seen, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_full_frame();
        test_overrun_ack();
        test_gap_discard();
        test_timeout_edge();
        test_mid_reset();
        test_ack_with_flag();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
